// File: rtl/oam_dma_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : oam_dma_ctrl_if                                     |
// | Description : CPU-side, memory-side and OAM-side signals of the   |
// |               OAM DMA controller, bundled for port connection.    |
// | Revision    : 1.0 - initial release                               |
// +------------------------------------------------------------------+
interface oam_dma_ctrl_if;
  logic        cpu_clk_en;
  logic        cpu_cyc_par;
  logic        stall;
  logic        dma_req;
  logic [7:0]  dma_page;
  logic [7:0]  mem_rd_data;
  logic        cpu_sus;
  logic [15:0] dma_addr;
  logic        dma_re;
  logic        oam_wr_en;
  logic [7:0]  oam_wr_data;
  logic        busy;
  logic        done;

  // DMA controller side
  modport master (
    input  cpu_clk_en, cpu_cyc_par, stall, dma_req, dma_page, mem_rd_data,
    output cpu_sus, dma_addr, dma_re, oam_wr_en, oam_wr_data, busy, done
  );

  // System side: CPU timing, $4014 decode, cpu_memory and PPU port
  modport slave (
    output cpu_clk_en, cpu_cyc_par, stall, dma_req, dma_page, mem_rd_data,
    input  cpu_sus, dma_addr, dma_re, oam_wr_en, oam_wr_data, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/oam_dma_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : oam_dma_ctrl                                        |
// | Description : OAM DMA. On a $4014 write, suspends the CPU, aligns |
// |               to an even CPU cycle, then copies PAGE_BYTES bytes  |
// |               from {page,idx} into OAMDATA as READ/WRITE tick     |
// |               pairs (513 or 514 CPU ticks for a full page).       |
// | Revision    : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module oam_dma_ctrl #(
  parameter int PAGE_BYTES = 256
) (
  input  wire logic      clock,
  input  wire logic      reset_n,
  oam_dma_ctrl_if.master bus
);

  localparam logic [7:0] c_last_idx = 8'(PAGE_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_idx;
  logic [7:0]  w_idx_next;
  logic [7:0]  r_page;
  logic [7:0]  w_page_next;
  logic        r_done;
  logic        w_done_next;
  logic [7:0]  r_wdata;
  logic [7:0]  w_wdata_next;
  logic        w_tick;

  // A tick is a CPU cycle boundary that save-state stall is not freezing
  assign w_tick = bus.cpu_clk_en & ~bus.stall;

  // State, index, page, last written byte and done flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_idx   <= 8'h00;
      r_page  <= 8'h00;
      r_done  <= 1'b0;
      r_wdata <= 8'h00;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_page  <= w_page_next;
      r_done  <= w_done_next;
      r_wdata <= w_wdata_next;
    end
  end

  // Next-state logic; nothing advances except on a tick. A pending done
  // pulse is held through a stall so it is neither lost nor shown stalled.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_page_next  = r_page;
    w_wdata_next = r_wdata;
    w_done_next  = bus.stall ? r_done : 1'b0;
    if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.dma_req) begin
            w_page_next  = bus.dma_page;
            w_idx_next   = 8'h00;
            w_state_next = ST_HALT;
          end
        end
        ST_HALT: begin
          // Odd HALT cycle means the next tick is even: read straight away
          w_state_next = bus.cpu_cyc_par ? ST_READ : ST_ALIGN;
        end
        ST_ALIGN: begin
          w_state_next = ST_READ;
        end
        ST_READ: begin
          w_state_next = ST_WRITE;
        end
        ST_WRITE: begin
          w_wdata_next = bus.mem_rd_data;
          if (r_idx == c_last_idx) begin
            w_idx_next   = 8'h00;
            w_state_next = ST_IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_idx_next   = r_idx + 8'd1;
            w_state_next = ST_READ;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Bus ownership and read request are pure functions of the state
  assign bus.cpu_sus  = (r_state != ST_IDLE);
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.dma_re   = (r_state == ST_READ);
  assign bus.dma_addr = (r_state == ST_READ) ? {r_page, r_idx} : 16'h0000;

  // OAM write strobe is the WRITE tick itself; data comes straight from
  // the registered memory output and otherwise holds the last byte written
  assign bus.oam_wr_en   = (r_state == ST_WRITE) & w_tick;
  assign bus.oam_wr_data = (r_state == ST_WRITE) ? bus.mem_rd_data : r_wdata;
  assign bus.done        = r_done & ~bus.stall;

endmodule
`default_nettype wire
